button_debounce: RTL
====================

Name: button_debounce

Overview:
Conditions one raw mechanical pushbutton or switch pin for the modboard CPLD. It synchronises the pin, rejects bounce and glitches, and produces a clean level plus single-cycle press, release and tick pulses. It sits directly upstream of the LED/ripple counter stage: that stage advances on `tick` instead of being clocked by the raw pin. An optional auto-repeat makes `tick` pulse periodically while the button is held.

Parameters:
- ACTIVE_LOW, 1: 1 = pin reads 0 when pressed; the raw pin is inverted after synchronisation.
- SYNC_STAGES, 2: synchroniser flop count; minimum 2.
- DEBOUNCE_CYCLES, 50000: consecutive agreeing samples required to accept a change. Minimum 1; elaboration error if < 1.
- REPEAT_EN, 0: 1 = auto-repeat ticks while held.
- REPEAT_DELAY, 25000000: cycles from the press edge to the first repeat tick.
- REPEAT_PERIOD, 5000000: cycles between subsequent repeat ticks; minimum 1.

Ports:
- clk, input, 1: system clock; all state on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- btn_raw, input, 1: raw pin, asynchronous to clk.
- btn_level, output, 1: debounced state, 1 = pressed.
- press_pulse, output, 1: one-cycle strobe on an accepted press.
- release_pulse, output, 1: one-cycle strobe on an accepted release.
- tick, output, 1: press_pulse OR repeat strobe; feeds the downstream counter enable.

Behaviour:
- Reset (async assert, sync-free release):
  - btn_level, press_pulse, release_pulse and tick are all 0.
  - Synchroniser flops load the released value (1 if ACTIVE_LOW, else 0).
  - FSM goes to RELEASED; all counters are 0.
- Synchroniser: SYNC_STAGES flops, then polarity normalisation, giving `s` (1 = pressed). A pin change is visible at `s` after SYNC_STAGES edges.
- FSM states:
  - RELEASED: if s=1, go to ARM_PRESS with db_cnt=1.
  - ARM_PRESS: if s=0, return to RELEASED with db_cnt=0 (glitch rejected). If s=1 and db_cnt==DEBOUNCE_CYCLES-1, go to PRESSED. Otherwise db_cnt++.
  - PRESSED: if s=0, go to ARM_RELEASE with db_cnt=1.
  - ARM_RELEASE: mirror of ARM_PRESS, with PRESSED as the glitch-return state and RELEASED as the accept state.
- DEBOUNCE_CYCLES=1: RELEASED goes directly to PRESSED on the first s=1 sample; the ARM states are skipped.
- Output timing:
  - btn_level is registered and equals (state ∈ {PRESSED, ARM_RELEASE}).
  - press_pulse is high for exactly the one cycle in which btn_level first reads 1.
  - release_pulse is high for exactly the one cycle in which btn_level first reads 0.
  - Latency from a clean pin edge to the pulse: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Counter widths:
  - db_cnt is $clog2(DEBOUNCE_CYCLES+1) bits and saturates; it never wraps.
  - rep_cnt is sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- Auto-repeat (REPEAT_EN=1 only):
  - rep_cnt clears on press acceptance.
  - rep_cnt counts only while in PRESSED, and freezes in ARM_RELEASE.
  - A repeat strobe fires when rep_cnt reaches REPEAT_DELAY; rep_cnt is then reloaded so later strobes fire every REPEAT_PERIOD.
  - Release acceptance clears rep_cnt; no repeat strobe is issued on or after that cycle.
  - A bounce during hold (PRESSED → ARM_RELEASE → PRESSED) does not restart the repeat delay.
- REPEAT_EN=0: tick == press_pulse.
- Simultaneous events: press_pulse and release_pulse are never high in the same cycle. tick is high for one cycle even when a repeat and a press coincide (impossible by construction, but the OR guarantees it).
- Reset mid-debounce: all progress is discarded. If the button is still held after rst_n rises, a full sync + debounce period elapses, then one press_pulse is emitted.

Decomposition:
- Package modboard_pkg holds:
  - constant CLK_HZ
  - default debounce/repeat cycle constants derived from CLK_HZ
  - a 2-bit FSM state typedef: RELEASED, ARM_PRESS, PRESSED, ARM_RELEASE.
- One sub-module, sync_chain: a parameterised SYNC_STAGES flop chain with a reset value parameter. It is reused for the other modboard pin inputs.

Test Plan (parameters for all cases: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1):
1. Reset with btn_raw=1 → all outputs 0. Drop btn_raw to 0 and hold → press_pulse and tick high exactly at cycle 6 after the drop, btn_level=1 from cycle 6.
2. Bounce: btn_raw low 3 cycles, high 1, low 3, high → no pulses, btn_level stays 0.
3. From pressed, release btn_raw to 1 and hold → release_pulse at cycle 6 after the edge, btn_level=0; a 2-cycle bounce during release delays it by a full re-count.
4. REPEAT_EN=1, REPEAT_DELAY=10, REPEAT_PERIOD=3, hold 25 cycles after press accepted → ticks at +0, +10, +13, +16, +19, +22; release → no further ticks.
5. Assert rst_n low during ARM_PRESS with btn held → outputs 0 immediately. After rst_n rises, exactly one press_pulse arrives 6 cycles later.
6. DEBOUNCE_CYCLES=1: single-cycle low glitch (after sync) → accepted press at SYNC_STAGES+1; confirms the minimum-parameter path.

Source files
------------

// File: rtl/modboard_pkg.sv
// Shared constants and types for the modboard CPLD pin-conditioning logic.
package modboard_pkg;

    // Board oscillator frequency; all default cycle counts derive from it.
    localparam int unsigned CLK_HZ = 50_000_000;

    // 1 ms debounce window, 0.5 s first repeat, 0.1 s repeat period.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 1000;
    localparam int unsigned REPEAT_DELAY_DEFAULT    = CLK_HZ / 2;
    localparam int unsigned REPEAT_PERIOD_DEFAULT   = CLK_HZ / 10;

    // Debounce state machine encoding.
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } db_state_e;

    // Larger of two cycle counts, used to size shared counters.
    function automatic int unsigned maxOf(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for an asynchronous pin; reset loads the idle pin level.
module sync_chain #(
    parameter int unsigned STAGES      = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    if (STAGES < 2) begin : gStagesCheck
        $error("sync_chain: STAGES must be at least 2");
    end

    logic [STAGES-1:0] chain_q;

    // Shift the raw pin through the chain; the last flop is the safe sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= {STAGES{RESET_VALUE}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Pushbutton conditioner: synchronise, debounce, and emit press/release/tick strobes
// with optional auto-repeat while the button is held.
module button_debounce
    import modboard_pkg::*;
#(
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic tick
);

    if (DEBOUNCE_CYCLES < 1) begin : gDebounceCheck
        $error("button_debounce: DEBOUNCE_CYCLES must be at least 1");
    end
    if (REPEAT_PERIOD < 1) begin : gPeriodCheck
        $error("button_debounce: REPEAT_PERIOD must be at least 1");
    end

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned REP_MAX = maxOf(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
    localparam logic [REP_W-1:0] REP_ONE     = REP_W'(1);
    localparam logic [REP_W-1:0] REP_DELAY_C = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_PER_C   = REP_W'(REPEAT_PERIOD);

    logic syncRaw;
    logic pressedNow;

    sync_chain #(
        .STAGES      (SYNC_STAGES),
        .RESET_VALUE (ACTIVE_LOW ? 1'b1 : 1'b0)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (btn_raw),
        .q_o   (syncRaw)
    );

    assign pressedNow = ACTIVE_LOW ? ~syncRaw : syncRaw;

    db_state_e        state_q, state_d;
    logic [DB_W-1:0]  dbCnt_q, dbCnt_d;
    logic [REP_W-1:0] repCnt_q, repCnt_d;
    logic [REP_W-1:0] repNext;
    logic             repFirstDone_q, repFirstDone_d;
    logic             btnLevel_q, btnLevel_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             tick_q, tick_d;
    logic             repStrobe;

    // Next-state logic: debounce FSM, edge strobes and the auto-repeat counter.
    always_comb begin
        state_d        = state_q;
        dbCnt_d        = dbCnt_q;
        repCnt_d       = repCnt_q;
        repFirstDone_d = repFirstDone_q;
        repNext        = repCnt_q + REP_ONE;
        repStrobe      = 1'b0;

        case (state_q)
            RELEASED: begin
                if (pressedNow) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = PRESSED;
                        dbCnt_d = '0;
                    end else begin
                        state_d = ARM_PRESS;
                        dbCnt_d = DB_ONE;
                    end
                end
            end
            ARM_PRESS: begin
                if (!pressedNow) begin
                    state_d = RELEASED;
                    dbCnt_d = '0;
                end else if (dbCnt_q >= DB_LAST) begin
                    state_d = PRESSED;
                    dbCnt_d = '0;
                end else begin
                    dbCnt_d = dbCnt_q + DB_ONE;
                end
            end
            PRESSED: begin
                if (!pressedNow) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = RELEASED;
                        dbCnt_d = '0;
                    end else begin
                        state_d = ARM_RELEASE;
                        dbCnt_d = DB_ONE;
                    end
                end
            end
            default: begin
                if (pressedNow) begin
                    state_d = PRESSED;
                    dbCnt_d = '0;
                end else if (dbCnt_q >= DB_LAST) begin
                    state_d = RELEASED;
                    dbCnt_d = '0;
                end else begin
                    dbCnt_d = dbCnt_q + DB_ONE;
                end
            end
        endcase

        btnLevel_d = (state_d == PRESSED) || (state_d == ARM_RELEASE);
        press_d    = btnLevel_d && !btnLevel_q;
        release_d  = !btnLevel_d && btnLevel_q;

        if (REPEAT_EN) begin
            if (press_d || release_d) begin
                repCnt_d       = '0;
                repFirstDone_d = 1'b0;
            end else if ((state_q == PRESSED) && (state_d == PRESSED)) begin
                if (repNext == (repFirstDone_q ? REP_PER_C : REP_DELAY_C)) begin
                    repStrobe      = 1'b1;
                    repCnt_d       = '0;
                    repFirstDone_d = 1'b1;
                end else begin
                    repCnt_d = repNext;
                end
            end
        end

        tick_d = press_d | repStrobe;
    end

    // State and registered outputs; reset discards any debounce or repeat progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RELEASED;
            dbCnt_q        <= '0;
            repCnt_q       <= '0;
            repFirstDone_q <= 1'b0;
            btnLevel_q     <= 1'b0;
            press_q        <= 1'b0;
            release_q      <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            dbCnt_q        <= dbCnt_d;
            repCnt_q       <= repCnt_d;
            repFirstDone_q <= repFirstDone_d;
            btnLevel_q     <= btnLevel_d;
            press_q        <= press_d;
            release_q      <= release_d;
            tick_q         <= tick_d;
        end
    end

    assign btn_level     = btnLevel_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign tick          = tick_q;

endmodule
